anim_sequencer: RTL and testbench

- Parametrised, clocked replacement for the combinational state-to-sprite mapping in the fighter render path.
- Holds a per-state animation table with frame count, hold ticks and loop/one-shot mode.
- Steps frames on the video frame tick, with restart on state change, retrigger and freeze (hitstop) support.
- Sits between the character FSM (anim_state) and the sprite ROM address logic (sprite_id).

---
 rtl/anim_pkg.sv | 33 +++
 rtl/anim_cfg_table.sv | 87 ++++++++
 rtl/anim_sequencer.sv | 138 +++++++++++++
 tb/tb_anim_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared types and default animation table for the fighter sprite sequencer.
package anim_pkg;

   localparam int BASE_STRIDE_DEF = 16;
   localparam int CFG_W           = 16;

   typedef enum logic [3:0] {
      ANIM_IDLE = 4'd0,
      ANIM_WALK = 4'd1,
      ANIM_JUMP = 4'd2,
      ANIM_ATK1 = 4'd3,
      ANIM_ATK2 = 4'd4,
      ANIM_HIT  = 4'd5,
      ANIM_LOSE = 4'd6
   } anim_state_e;

   typedef struct packed {
      logic [CFG_W-1:0] frames;
      logic [CFG_W-1:0] hold;
      logic             loop;
   } anim_cfg_t;

   function automatic anim_cfg_t anim_default(input int s);
      anim_cfg_t c;
      c = '{frames: 16'd1, hold: 16'd0, loop: 1'b1};
      if (s == int'(ANIM_WALK)) c = '{frames: 16'd4, hold: 16'd5, loop: 1'b1};
      if (s == int'(ANIM_ATK1)) c = '{frames: 16'd6, hold: 16'd3, loop: 1'b0};
      if (s == int'(ANIM_ATK2)) c = '{frames: 16'd8, hold: 16'd3, loop: 1'b0};
      if (s == int'(ANIM_LOSE)) c = '{frames: 16'd4, hold: 16'd7, loop: 1'b0};
      return c;
   endfunction

endpackage

// File: rtl/anim_cfg_table.sv
// Per-state animation config register file, reset to the default table.
module anim_cfg_table
   import anim_pkg::*;
#(
   parameter int NUM_STATES = 8,
   parameter int STATE_W    = 4,
   parameter int FRAME_W    = 6,
   parameter int HOLD_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [STATE_W-1:0]    wr_state,
   input  logic [FRAME_W-1:0]    wr_frames,
   input  logic [HOLD_W-1:0]     wr_hold,
   input  logic                  wr_loop,
   input  logic [STATE_W-1:0]    rd_state,
   output logic [FRAME_W-1:0]    rd_frames,
   output logic [HOLD_W-1:0]     rd_hold,
   output logic                  rd_loop,
   output logic [NUM_STATES-1:0] loop_vec
);

   logic [FRAME_W-1:0] frames_q [NUM_STATES];
   logic [FRAME_W-1:0] frames_d [NUM_STATES];
   logic [HOLD_W-1:0]  hold_q   [NUM_STATES];
   logic [HOLD_W-1:0]  hold_d   [NUM_STATES];
   logic               loop_q   [NUM_STATES];
   logic               loop_d   [NUM_STATES];

   logic [FRAME_W-1:0] dflt_frames [NUM_STATES];
   logic [HOLD_W-1:0]  dflt_hold   [NUM_STATES];
   logic               dflt_loop   [NUM_STATES];

   always_comb begin
      anim_cfg_t c;
      for (int i = 0; i < NUM_STATES; i++) begin
         c              = anim_default(i);
         dflt_frames[i] = FRAME_W'(c.frames);
         dflt_hold[i]   = HOLD_W'(c.hold);
         dflt_loop[i]   = c.loop;
      end
   end

   // Out-of-range write addresses match no entry and are dropped.
   always_comb begin
      frames_d = frames_q;
      hold_d   = hold_q;
      loop_d   = loop_q;
      for (int i = 0; i < NUM_STATES; i++) begin
         if (we && wr_state == STATE_W'(i)) begin
            frames_d[i] = wr_frames;
            hold_d[i]   = wr_hold;
            loop_d[i]   = wr_loop;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            frames_q[i] <= dflt_frames[i];
            hold_q[i]   <= dflt_hold[i];
            loop_q[i]   <= dflt_loop[i];
         end
      end else begin
         frames_q <= frames_d;
         hold_q   <= hold_d;
         loop_q   <= loop_d;
      end
   end

   always_comb begin
      rd_frames = '0;
      rd_hold   = '0;
      rd_loop   = 1'b1;
      for (int i = 0; i < NUM_STATES; i++) begin
         loop_vec[i] = loop_q[i];
         if (rd_state == STATE_W'(i)) begin
            rd_frames = frames_q[i];
            rd_hold   = hold_q[i];
            rd_loop   = loop_q[i];
         end
      end
   end

endmodule

// File: rtl/anim_sequencer.sv
// Clocked animation sequencer: steps sprite frames on the video frame tick.
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int NUM_STATES  = 8,
   parameter int STATE_W     = 4,
   parameter int FRAME_W     = 6,
   parameter int HOLD_W      = 4,
   parameter int ID_W        = 12,
   parameter int BASE_STRIDE = BASE_STRIDE_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic [STATE_W-1:0] anim_state,
   input  logic               anim_restart,
   input  logic               freeze,
   input  logic               cfg_we,
   input  logic [STATE_W-1:0] cfg_state,
   input  logic [FRAME_W-1:0] cfg_frames,
   input  logic [HOLD_W-1:0]  cfg_hold,
   input  logic               cfg_loop,
   output logic [ID_W-1:0]    sprite_id,
   output logic [FRAME_W-1:0] frame_idx,
   output logic [STATE_W-1:0] cur_state,
   output logic               anim_busy,
   output logic               anim_done
);

   logic [STATE_W-1:0]    cur_state_q, cur_state_d;
   logic [FRAME_W-1:0]    frame_q, frame_d;
   logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]       sprite_q, sprite_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  done_flag_q, done_flag_d;

   logic [FRAME_W-1:0]    rd_frames, last_frame;
   logic [HOLD_W-1:0]     rd_hold;
   logic                  rd_loop, eff_loop, restart, advance;
   logic [NUM_STATES-1:0] loop_vec;
   logic [STATE_W-1:0]    eff;

   anim_cfg_table #(
      .NUM_STATES (NUM_STATES),
      .STATE_W    (STATE_W),
      .FRAME_W    (FRAME_W),
      .HOLD_W     (HOLD_W)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (cfg_we),
      .wr_state  (cfg_state),
      .wr_frames (cfg_frames),
      .wr_hold   (cfg_hold),
      .wr_loop   (cfg_loop),
      .rd_state  (cur_state_q),
      .rd_frames (rd_frames),
      .rd_hold   (rd_hold),
      .rd_loop   (rd_loop),
      .loop_vec  (loop_vec)
   );

   always_comb begin
      eff      = (int'(anim_state) < NUM_STATES) ? anim_state : '0;
      eff_loop = 1'b1;
      for (int i = 0; i < NUM_STATES; i++) begin
         if (eff == STATE_W'(i)) eff_loop = loop_vec[i];
      end
      restart    = (eff != cur_state_q) || anim_restart;
      advance    = frame_tick && !freeze && !restart;
      last_frame = (rd_frames == '0) ? '0 : rd_frames - 1'b1;
   end

   always_comb begin
      cur_state_d = cur_state_q;
      frame_d     = frame_q;
      hold_cnt_d  = hold_cnt_q;
      sprite_d    = sprite_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      done_flag_d = done_flag_q;
      if (restart) begin
         cur_state_d = eff;
         frame_d     = '0;
         hold_cnt_d  = '0;
         done_flag_d = 1'b0;
         busy_d      = ~eff_loop;
         sprite_d    = ID_W'(int'(eff) * BASE_STRIDE);
      end else if (advance) begin
         if (hold_cnt_q < rd_hold) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
         end else begin
            hold_cnt_d = '0;
            // >= keeps a shrunk table entry from playing past its end.
            if (frame_q >= last_frame) begin
               if (rd_loop) begin
                  frame_d = '0;
               end else if (!done_flag_q) begin
                  done_d      = 1'b1;
                  done_flag_d = 1'b1;
                  busy_d      = 1'b0;
               end
            end else begin
               frame_d = frame_q + 1'b1;
            end
            sprite_d = ID_W'(int'(cur_state_q) * BASE_STRIDE + int'(frame_d));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state_q <= '0;
         frame_q     <= '0;
         hold_cnt_q  <= '0;
         sprite_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         done_flag_q <= 1'b0;
      end else begin
         cur_state_q <= cur_state_d;
         frame_q     <= frame_d;
         hold_cnt_q  <= hold_cnt_d;
         sprite_q    <= sprite_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         done_flag_q <= done_flag_d;
      end
   end

   assign sprite_id = sprite_q;
   assign frame_idx = frame_q;
   assign cur_state = cur_state_q;
   assign anim_busy = busy_q;
   assign anim_done = done_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer.
// Directed sequences, monitor-side compare.
module tb_anim_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [3:0]  anim_state = '0;
  logic        anim_restart = 1'b0;
  logic        freeze = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_state = '0;
  logic [5:0]  cfg_frames = '0;
  logic [3:0]  cfg_hold = '0;
  logic        cfg_loop = 1'b0;
  logic [11:0] sprite_id;
  logic [5:0]  frame_idx;
  logic [3:0]  cur_state;
  logic        anim_busy;
  logic        anim_done;

  anim_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .anim_state   (anim_state),
    .anim_restart (anim_restart),
    .freeze       (freeze),
    .cfg_we       (cfg_we),
    .cfg_state    (cfg_state),
    .cfg_frames   (cfg_frames),
    .cfg_hold     (cfg_hold),
    .cfg_loop     (cfg_loop),
    .sprite_id    (sprite_id),
    .frame_idx    (frame_idx),
    .cur_state    (cur_state),
    .anim_busy    (anim_busy),
    .anim_done    (anim_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] sid;
    logic [5:0]  fi;
    logic [3:0]  cs;
    logic        busy;
    int          dn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   done_seen = 0;
  int   done_exp = 0;

  always @(negedge clk) begin
    exp_t e;
    if (anim_done === 1'b1) done_seen++;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (sprite_id === e.sid && frame_idx === e.fi &&
          cur_state === e.cs && anim_busy === e.busy &&
          done_seen == e.dn)
        passed++;
      else
        $display("FAIL %s: got sid=%h fi=%0d cs=%0d busy=%b dones=%0d, want sid=%h fi=%0d cs=%0d busy=%b dones=%0d",
                 e.name, sprite_id, frame_idx, cur_state,
                 anim_busy, done_seen,
                 e.sid, e.fi, e.cs, e.busy, e.dn);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string n, input int sid,
                     input int fi, input int cs,
                     input bit busy);
    exp_t e;
    e.name = n;
    e.sid  = 12'(sid);
    e.fi   = 6'(fi);
    e.cs   = 4'(cs);
    e.busy = busy;
    e.dn   = done_exp;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic now_chk(input string n, input int sid,
                         input int fi, input int cs,
                         input bit busy, input bit dn);
    total++;
    if (sprite_id === 12'(sid) && frame_idx === 6'(fi) &&
        cur_state === 4'(cs) && anim_busy === busy &&
        anim_done === dn)
      passed++;
    else
      $display("FAIL %s: got sid=%h fi=%0d cs=%0d busy=%b done=%b, want sid=%h fi=%0d cs=%0d busy=%b done=%b",
               n, sprite_id, frame_idx, cur_state,
               anim_busy, anim_done,
               12'(sid), fi, cs, busy, dn);
  endtask

  task automatic cfg(input int s, input int f,
                     input int h, input bit l);
    cfg_we = 1'b1;
    cfg_state = 4'(s);
    cfg_frames = 6'(f);
    cfg_hold = 4'(h);
    cfg_loop = l;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    chk("reset", 'h000, 0, 0, 0);
    rst_n = 1'b1;
    cyc();
    tick(10);
    chk("idle_steady", 'h000, 0, 0, 0);

    anim_state = 4'd1;
    cyc();
    chk("walk_enter", 'h010, 0, 1, 0);
    tick(5);
    chk("walk_hold", 'h010, 0, 1, 0);
    tick(1);
    chk("walk_f1", 'h011, 1, 1, 0);
    tick(12);
    chk("walk_f3", 'h013, 3, 1, 0);
    tick(6);
    chk("walk_wrap", 'h010, 0, 1, 0);

    anim_state = 4'd3;
    cyc();
    chk("atk1_enter", 'h030, 0, 3, 1);
    tick(23);
    chk("atk1_pre_end", 'h035, 5, 3, 1);
    tick(1);
    done_exp = 1;
    chk("atk1_done", 'h035, 5, 3, 0);
    tick(10);
    chk("atk1_hold_last", 'h035, 5, 3, 0);

    anim_state = 4'd4;
    cyc();
    chk("atk2_enter", 'h040, 0, 4, 1);
    tick(8);
    chk("atk2_f2", 'h042, 2, 4, 1);
    freeze = 1'b1;
    tick(20);
    chk("freeze_hold", 'h042, 2, 4, 1);
    anim_restart = 1'b1;
    cyc();
    anim_restart = 1'b0;
    chk("retrigger", 'h040, 0, 4, 1);
    freeze = 1'b0;

    anim_state = 4'd9;
    cyc();
    chk("out_of_range", 'h000, 0, 0, 0);

    anim_state = 4'd1;
    cyc();
    tick(18);
    chk("walk_f3_again", 'h013, 3, 1, 0);
    cfg(1, 2, 0, 1'b1);
    tick(1);
    chk("cfg_shrink_wrap", 'h010, 0, 1, 0);
    tick(1);
    chk("cfg_new_f1", 'h011, 1, 1, 0);
    tick(1);
    chk("cfg_new_wrap", 'h010, 0, 1, 0);

    cfg(2, 0, 0, 1'b0);
    anim_state = 4'd2;
    cyc();
    chk("zero_frames_enter", 'h020, 0, 2, 1);
    tick(1);
    done_exp = 2;
    chk("zero_frames_done", 'h020, 0, 2, 0);
    tick(3);
    chk("zero_frames_no_redone", 'h020, 0, 2, 0);

    anim_state = 4'd4;
    cyc();
    tick(20);
    chk("atk2_f5", 'h045, 5, 4, 1);
    #2 rst_n = 1'b0;
    anim_state = 4'd1;
    #1;
    now_chk("async_now", 'h000, 0, 0, 0, 0);
    chk("async_reset", 'h000, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_reset_walk", 'h010, 0, 1, 0);
    tick(5);
    chk("dflt_walk_hold", 'h010, 0, 1, 0);
    tick(1);
    chk("dflt_walk_f1", 'h011, 1, 1, 0);
    anim_state = 4'd2;
    cyc();
    chk("dflt_jump_loop", 'h020, 0, 2, 0);

    cyc();
    @(negedge clk);
    #1;
    total++;
    if (done_seen == done_exp)
      passed++;
    else
      $display("FAIL done_count: got %0d want %0d",
               done_seen, done_exp);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
